// File: rtl/mem_port_pkg.sv
// rtl/mem_port_pkg.sv - shared types and constants for the memory port sequencer
package mem_port_pkg;

  localparam int DEFAULT_MAX_WAIT = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_DATA   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] writedata;
    logic        read;
    logic        write;
  } bus_req_t;

  // States in which a transfer is in flight on the unified port.
  function automatic logic is_transfer(input seq_state_t s);
    return (s == ST_FETCH) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - per-transfer waitrequest counter with timeout compare
module bus_wait_timer
  import mem_port_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam int            CW    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && !timeout) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the stall cycle that would make the run reach MAX_WAIT.
  assign timeout = count_en && (count >= LIMIT);

endmodule

// File: rtl/mem_port_sequencer.sv
// rtl/mem_port_sequencer.sv - sequences instruction fetch and data access over one memory port
module mem_port_sequencer
  import mem_port_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic [31:0] cpu_data_writedata,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] bus_address,
  output logic [31:0] bus_writedata,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        bus_error
);

  seq_state_t  state;
  seq_state_t  state_next;
  bus_req_t    req;
  logic [31:0] instr_buf;
  logic [31:0] data_buf;
  logic        wait_timeout;
  logic        xfer_done;

  assign xfer_done = is_transfer(state) && !bus_waitrequest;

  bus_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!is_transfer(state)),
    .count_en(is_transfer(state) && bus_waitrequest),
    .timeout (wait_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cpu_active) state_next = ST_FETCH;
      ST_FETCH: begin
        if (!bus_waitrequest)  state_next = ST_DECODE;
        else if (wait_timeout) state_next = ST_ERROR;
      end
      ST_DECODE: state_next = (cpu_data_read || cpu_data_write) ? ST_DATA : ST_COMMIT;
      ST_DATA: begin
        if (!bus_waitrequest)  state_next = ST_COMMIT;
        else if (wait_timeout) state_next = ST_ERROR;
      end
      ST_COMMIT: state_next = cpu_active ? ST_FETCH : ST_IDLE;
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Strobes are gated by reset so an aborted transfer drops in the reset cycle itself.
  always_comb begin
    req            = '0;
    cpu_clk_enable = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          req.read    = 1'b1;
          req.address = cpu_instr_address;
        end
        ST_DATA: begin
          req.address = cpu_data_address;
          if (cpu_data_write) begin
            req.write     = 1'b1;
            req.writedata = cpu_data_writedata;
          end else begin
            req.read = 1'b1;
          end
        end
        ST_COMMIT: cpu_clk_enable = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_address   = req.address;
  assign bus_writedata = req.writedata;
  assign bus_read      = req.read;
  assign bus_write     = req.write;
  assign bus_error     = (state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_buf <= '0;
      data_buf  <= '0;
    end else if (xfer_done) begin
      if (state == ST_FETCH) begin
        instr_buf <= bus_readdata;
      end else begin
        data_buf <= cpu_data_write ? 32'h0 : bus_readdata;
      end
    end
  end

  assign cpu_instr_readdata = instr_buf;
  assign cpu_data_readdata  = data_buf;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb/tb_mem_port_sequencer.sv - self-checking bench for mem_port_sequencer
module tb_mem_port_sequencer;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_active = 1'b0;
  logic        cpu_clk_enable;
  logic [31:0] cpu_instr_address = 32'h0;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address = 32'h0;
  logic [31:0] cpu_data_writedata = 32'h0;
  logic        cpu_data_read = 1'b0;
  logic        cpu_data_write = 1'b0;
  logic [31:0] cpu_data_readdata;
  logic [31:0] bus_address;
  logic [31:0] bus_writedata;
  logic        bus_read;
  logic        bus_write;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        bus_error;

  always #5 clk = ~clk;

  mem_port_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_active        (cpu_active),
    .cpu_clk_enable    (cpu_clk_enable),
    .cpu_instr_address (cpu_instr_address),
    .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address  (cpu_data_address),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_write    (cpu_data_write),
    .cpu_data_readdata (cpu_data_readdata),
    .bus_address       (bus_address),
    .bus_writedata     (bus_writedata),
    .bus_read          (bus_read),
    .bus_write         (bus_write),
    .bus_waitrequest   (bus_waitrequest),
    .bus_readdata      (bus_readdata),
    .bus_error         (bus_error)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd;
    logic        wr;
    int          wf;
    int          wd;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] data;
    int          cycles;
    int          reads;
    int          writes;
  } exp_t;

  vec_t        vecs[7];
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_data = 32'h0;

  // Memory slave model: fetch is recognised by a read at the current PC.
  logic [31:0] cur_instr = 32'h0;
  logic [31:0] cur_rdata = 32'h0;
  int          cur_wf = 0;
  int          cur_wd = 0;
  int          wc = 0;
  logic        is_fetch;

  always_comb begin
    bus_waitrequest = 1'b0;
    bus_readdata    = 32'h0;
    is_fetch        = bus_read && (bus_address == cpu_instr_address);
    if (bus_read || bus_write) begin
      bus_waitrequest = wc < (is_fetch ? cur_wf : cur_wd);
      bus_readdata    = is_fetch ? cur_instr : cur_rdata;
    end
  end

  always @(posedge clk) begin
    if (reset) wc <= 0;
    else if ((bus_read || bus_write) && bus_waitrequest) wc <= wc + 1;
    else wc <= 0;
  end

  // Protocol monitor: exclusive strobes, request held stable while stalled.
  int          viol = 0;
  logic        pw = 1'b0;
  logic [31:0] pa, pd;
  logic        pr, pwr;

  always @(negedge clk) begin
    if (bus_read && bus_write) viol++;
    if (reset || bus_error) begin
      pw = 1'b0;
    end else begin
      if (pw && (bus_address !== pa || bus_read !== pr || bus_write !== pwr || bus_writedata !== pd))
        viol++;
      pw  = (bus_read || bus_write) && bus_waitrequest;
      pa  = bus_address;
      pd  = bus_writedata;
      pr  = bus_read;
      pwr = bus_write;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    cur_instr          = v.instr;
    cur_rdata          = v.rdata;
    cur_wf             = v.wf;
    cur_wd             = v.wd;
    cpu_instr_address  = v.pc;
    cpu_data_address   = v.daddr;
    cpu_data_writedata = v.wdata;
    cpu_data_read      = v.rd;
    cpu_data_write     = v.wr;
    cpu_active         = 1'b1;
  endtask

  task automatic run_instr(input vec_t v, input string tag);
    exp_t        e;
    exp_t        g;
    int          cyc = 0;
    int          nr = 0;
    int          nw = 0;
    logic [31:0] last_wd = 32'h0;
    logic [31:0] fetch_addr = 32'h0;
    set_inputs(v);
    if (v.wr) exp_data = 32'h0;
    else if (v.rd) exp_data = v.rdata;
    e.instr  = v.instr;
    e.data   = exp_data;
    e.cycles = 3 + v.wf + ((v.rd || v.wr) ? 1 + v.wd : 0);
    e.reads  = 1 + v.wf + ((v.rd && !v.wr) ? 1 + v.wd : 0);
    e.writes = v.wr ? 1 + v.wd : 0;
    sb.push_back(e);
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) fetch_addr = bus_address;
      if (bus_read) nr++;
      if (bus_write) begin
        nw++;
        last_wd = bus_writedata;
      end
      if (cpu_clk_enable) break;
    end
    g = sb.pop_front();
    check({tag, ".commit"}, {31'h0, cpu_clk_enable}, 32'h1);
    check({tag, ".fetch_addr"}, fetch_addr, v.pc);
    check({tag, ".cycles"}, 32'(cyc), 32'(g.cycles));
    check({tag, ".instr"}, cpu_instr_readdata, g.instr);
    check({tag, ".data"}, cpu_data_readdata, g.data);
    check({tag, ".reads"}, 32'(nr), 32'(g.reads));
    check({tag, ".writes"}, 32'(nw), 32'(g.writes));
    if (v.wr) check({tag, ".wdata"}, last_wd, v.wdata);
  endtask

  initial begin
    int n_rd;
    int n_en;
    int first_err;
    vec_t v;

    vecs[0] = '{32'hBFC00000, 32'h00851021, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 0, 0};
    vecs[1] = '{32'hBFC00004, 32'h8C820004, 32'h00001004, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 0, 2};
    vecs[2] = '{32'hBFC00008, 32'h3C011234, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 3, 0};
    vecs[3] = '{32'hBFC0000C, 32'hAC820000, 32'h00002000, 32'h12345678, 32'h55555555, 1'b1, 1'b1, 0, 0};
    vecs[4] = '{32'hBFC00010, 32'h8C830010, 32'h00000010, 32'h0,        32'hA5A55A5A, 1'b1, 1'b0, 1, 1};
    vecs[5] = '{32'hBFC00014, 32'hAC830020, 32'h00000020, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 0, 3};
    vecs[6] = '{32'hBFC00018, 32'h00A53021, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 2, 0};

    repeat (2) @(negedge clk);
    check("rst.bus_read", {31'h0, bus_read}, 32'h0);
    check("rst.bus_write", {31'h0, bus_write}, 32'h0);
    check("rst.clk_en", {31'h0, cpu_clk_enable}, 32'h0);
    check("rst.bus_error", {31'h0, bus_error}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.instr_buf", cpu_instr_readdata, 32'h0);
    check("rst.data_buf", cpu_data_readdata, 32'h0);
    check("idle.bus_read", {31'h0, bus_read}, 32'h0);

    for (int i = 0; i < 7; i++) run_instr(vecs[i], $sformatf("vec%0d", i));

    // cpu_active dropped in DECODE: the instruction still commits, then IDLE.
    v = '{32'hBFC00100, 32'h01094021, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0};
    set_inputs(v);
    @(negedge clk);
    @(negedge clk);
    cpu_active = 1'b0;
    @(negedge clk);
    check("halt.commit", {31'h0, cpu_clk_enable}, 32'h1);
    check("halt.instr", cpu_instr_readdata, 32'h01094021);
    n_rd = 0;
    n_en = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_read) n_rd++;
      if (cpu_clk_enable) n_en++;
    end
    check("halt.no_fetch", 32'(n_rd), 32'h0);
    check("halt.no_commit", 32'(n_en), 32'h0);

    // Reset in the middle of a stalled write.
    v = '{32'hBFC00200, 32'hAD280000, 32'h00003000, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, 0, 3};
    set_inputs(v);
    repeat (4) @(negedge clk);
    check("rstmid.write_before", {31'h0, bus_write}, 32'h1);
    reset = 1'b1;
    #1;
    check("rstmid.write_in_reset", {31'h0, bus_write}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cpu_active = 1'b0;
    n_rd = 0;
    n_en = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_read || bus_write) n_rd++;
      if (cpu_clk_enable) n_en++;
    end
    check("rstmid.idle_strobes", 32'(n_rd), 32'h0);
    check("rstmid.no_commit", 32'(n_en), 32'h0);
    check("rstmid.instr_buf", cpu_instr_readdata, 32'h0);

    // Fetch stalled forever: ERROR after MAX_WAIT wait cycles.
    v = '{32'hBFC00300, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 100, 0};
    set_inputs(v);
    n_rd = 0;
    n_en = 0;
    first_err = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus_read) n_rd++;
      if (cpu_clk_enable) n_en++;
      if (bus_error && first_err == 0) first_err = c;
    end
    check("tmo.error_cycle", 32'(first_err), 32'(MAX_WAIT + 1));
    check("tmo.read_cycles", 32'(n_rd), 32'(MAX_WAIT));
    check("tmo.no_commit", 32'(n_en), 32'h0);
    check("tmo.sticky", {31'h0, bus_error}, 32'h1);
    reset = 1'b1;
    cpu_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("tmo.cleared", {31'h0, bus_error}, 32'h0);

    check("protocol", 32'(viol), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
